ipctrl: RTL

IPCTRL -- requirements
Module: ipctrl

---
 rtl/router_pkg.sv | 38 +++
 rtl/route_compute.sv | 23 ++
 rtl/ipctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: direction indices, packet layout and request type.
package router_pkg;

   localparam int unsigned PKT_W     = 64;
   localparam int unsigned REQ_W     = 5;
   localparam int unsigned HOP_W     = 8;
   localparam int unsigned RSVD_W    = 5;
   localparam int unsigned PAYLOAD_W = 40;

   // Request bit positions, shared with the output controllers
   localparam int unsigned DIR_PE = 0;
   localparam int unsigned DIR_S  = 1;
   localparam int unsigned DIR_N  = 2;
   localparam int unsigned DIR_E  = 3;
   localparam int unsigned DIR_W  = 4;

   // Virtual-channel bit; odd buffer carries vc=1
   localparam int unsigned VC_BIT = 63;

   typedef logic [REQ_W-1:0] req_t;

   // Packet layout, MSB first: vc, xdir (0=E,1=W), ydir (0=N,1=S), reserved, hopx, hopy, payload
   typedef struct packed {
      logic                 vc;
      logic                 xdir;
      logic                 ydir;
      logic [RSVD_W-1:0]    rsvd;
      logic [HOP_W-1:0]     hopx;
      logic [HOP_W-1:0]     hopy;
      logic [PAYLOAD_W-1:0] payload;
   } pkt_t;

   // One-hot request for a direction index
   function automatic req_t dir_req(input int unsigned dir);
      return req_t'(1) << dir;
   endfunction

endpackage

// File: rtl/route_compute.sv
// XY route computation: picks the output direction and consumes one hop.
module route_compute
   import router_pkg::*;
(
   input  pkt_t pkt_in,
   output req_t req,
   output pkt_t pkt_out
);

   // X first, then Y, else deliver locally; guards keep hops from wrapping
   always_comb begin
      pkt_out = pkt_in;
      req     = dir_req(DIR_PE);
      if (pkt_in.hopx != '0) begin
         req          = pkt_in.xdir ? dir_req(DIR_W) : dir_req(DIR_E);
         pkt_out.hopx = pkt_in.hopx - HOP_W'(1);
      end else if (pkt_in.hopy != '0) begin
         req          = pkt_in.ydir ? dir_req(DIR_S) : dir_req(DIR_N);
         pkt_out.hopy = pkt_in.hopy - HOP_W'(1);
      end
   end

endmodule

// File: rtl/ipctrl.sv
// Input port controller: two parity-interleaved single-entry buffers between
// the upstream link and the output controllers.
module ipctrl
   import router_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             polarity,
   input  logic             send_in,
   input  logic [PKT_W-1:0] data_in,
   output logic             ready_in,
   output logic [REQ_W-1:0] req,
   input  logic [REQ_W-1:0] clear,
   output logic [PKT_W-1:0] data_out,
   output logic             vc_err
);

   logic even_vld, odd_vld;
   req_t even_req, odd_req;
   pkt_t even_pkt, odd_pkt;

   req_t rc_req;
   pkt_t rc_pkt;
   pkt_t link_pkt;

   logic off_vld;
   req_t off_req;
   pkt_t off_pkt;

   logic wr_en;
   logic clr_en;
   logic vc_bad;

   assign link_pkt = pkt_t'(data_in);

   route_compute u_route (
      .pkt_in  (link_pkt),
      .req     (rc_req),
      .pkt_out (rc_pkt)
   );

   // Link writes the odd buffer on even cycles and vice versa; switch sees the other one
   always_comb begin
      ready_in = polarity ? ~even_vld : ~odd_vld;
      off_vld  = polarity ? odd_vld  : even_vld;
      off_req  = polarity ? odd_req  : even_req;
      off_pkt  = polarity ? odd_pkt  : even_pkt;
      req      = off_vld ? off_req : '0;
      data_out = off_vld ? PKT_W'(off_pkt) : '0;
   end

   assign wr_en  = send_in & ready_in;
   assign clr_en = |(clear & req);
   // Expected vc equals target parity, which is ~polarity
   assign vc_bad = wr_en & (data_in[VC_BIT] == polarity);

   // Buffer state: write and clear always hit different buffers in one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         even_vld <= 1'b0;
         odd_vld  <= 1'b0;
         even_req <= '0;
         odd_req  <= '0;
         even_pkt <= '0;
         odd_pkt  <= '0;
      end else begin
         if (wr_en && !polarity) begin
            odd_vld <= 1'b1;
            odd_req <= rc_req;
            odd_pkt <= rc_pkt;
         end
         if (wr_en && polarity) begin
            even_vld <= 1'b1;
            even_req <= rc_req;
            even_pkt <= rc_pkt;
         end
         if (clr_en && !polarity) even_vld <= 1'b0;
         if (clr_en && polarity)  odd_vld  <= 1'b0;
      end
   end

   // Sticky wrong-virtual-channel flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vc_err <= 1'b0;
      else if (vc_bad) vc_err <= 1'b1;
   end

endmodule
